// File: rtl/ad9228_pkg.sv
// Shared types and constants for the AD9228 capture path.
package ad9228_pkg;

    localparam int unsigned ADC_DATA_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        READOUT = 3'd4
    } capture_state_t;

endpackage

// File: rtl/ad9228_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module ad9228_sample_ram
    import ad9228_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read data only changes on re_i, so it doubles as a holding stage.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ad9228_trigger_capture.sv
// Circular-buffer trigger capture on the gearbox word stream with a
// pre/post-trigger record played out on a valid/ready stream.
module ad9228_trigger_capture
    import ad9228_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ADC_DATA_WIDTH,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  dco,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic [AW:0]           pre_len,
    input  logic [AW:0]           post_len,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  cfg_err
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = AW + 2;

    capture_state_t        state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         trig_addr_q, trig_addr_d;
    logic [CW-1:0]         fill_cnt_q, fill_cnt_d;
    logic [CW-1:0]         post_cnt_q, post_cnt_d;
    logic [CW-1:0]         rd_left_q, rd_left_d;
    logic [CW-1:0]         pre_q, pre_d;
    logic [CW-1:0]         post_q, post_d;
    logic [DATA_WIDTH-1:0] thr_q, thr_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_vld_q, prev_vld_d;
    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  busy_q, busy_d;
    logic                  cfg_err_q, cfg_err_d;

    logic [SW-1:0]         cfg_sum_c;
    logic                  cfg_ok_c;
    logic                  crossing_c;
    logic                  adv_out_c;
    logic                  rd_en_c;
    logic                  we_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    assign cfg_sum_c  = SW'(pre_len) + SW'(post_len);
    assign cfg_ok_c   = (post_len != '0) && (cfg_sum_c <= SW'(DEPTH));
    assign crossing_c = prev_vld_q && (prev_q < thr_q) && (data_in >= thr_q);
    assign adv_out_c  = !m_valid_q || m_ready;
    // RAM output acts as the first prefetch stage; refill it whenever it drains.
    assign rd_en_c    = (state_q == READOUT) && !abort && (rd_left_q != '0)
                        && (!s1_vld_q || adv_out_c);

    ad9228_sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk_i   (dco),
        .we_i    (we_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .re_i    (rd_en_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data_c)
    );

    always_ff @(posedge dco or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_addr_q <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            rd_left_q   <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            thr_q       <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            trig_addr_q <= trig_addr_d;
            fill_cnt_q  <= fill_cnt_d;
            post_cnt_q  <= post_cnt_d;
            rd_left_q   <= rd_left_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            thr_q       <= thr_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        trig_addr_d = trig_addr_q;
        fill_cnt_d  = fill_cnt_q;
        post_cnt_d  = post_cnt_q;
        rd_left_d   = rd_left_q;
        pre_d       = pre_q;
        post_d      = post_q;
        thr_d       = thr_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        s1_vld_d    = s1_vld_q;
        s1_last_d   = s1_last_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        cfg_err_d   = cfg_err_q;
        we_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    if (cfg_ok_c) begin
                        thr_d      = threshold;
                        pre_d      = pre_len;
                        post_d     = post_len;
                        fill_cnt_d = '0;
                        post_cnt_d = '0;
                        prev_vld_d = 1'b0;
                        cfg_err_d  = 1'b0;
                        state_d    = (pre_len != '0) ? FILL : ARMED;
                    end else begin
                        cfg_err_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                if (data_valid_in) begin
                    we_c       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + AW'(1);
                    fill_cnt_d = fill_cnt_q + CW'(1);
                    prev_d     = data_in;
                    prev_vld_d = 1'b1;
                    if (fill_cnt_q + CW'(1) == pre_q) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (data_valid_in) begin
                    we_c       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + AW'(1);
                    prev_d     = data_in;
                    prev_vld_d = 1'b1;
                    if (crossing_c) begin
                        trig_addr_d = wr_ptr_q;
                        post_cnt_d  = CW'(1);
                        state_d     = (post_q > CW'(1)) ? POST : READOUT;
                    end
                end
            end
            POST: begin
                if (data_valid_in) begin
                    we_c       = 1'b1;
                    wr_ptr_d   = wr_ptr_q + AW'(1);
                    prev_d     = data_in;
                    post_cnt_d = post_cnt_q + CW'(1);
                    if (post_cnt_q + CW'(1) == post_q) begin
                        state_d = READOUT;
                    end
                end
            end
            READOUT: begin
                if (rd_en_c) begin
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    rd_left_d = rd_left_q - CW'(1);
                    s1_vld_d  = 1'b1;
                    s1_last_d = (rd_left_q == CW'(1));
                end else if (adv_out_c) begin
                    s1_vld_d  = 1'b0;
                end
                if (adv_out_c) begin
                    m_valid_d = s1_vld_q;
                    m_last_d  = s1_vld_q && s1_last_q;
                    if (s1_vld_q) begin
                        m_data_d = rd_data_c;
                    end
                end
                if (m_valid_q && m_ready && m_last_q) begin
                    state_d   = IDLE;
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Readout begins pre_len samples before the trigger sample's address.
        if ((state_q != READOUT) && (state_d == READOUT)) begin
            rd_ptr_d  = trig_addr_d - AW'(pre_q);
            rd_left_d = CW'(pre_q + post_q);
            s1_vld_d  = 1'b0;
            s1_last_d = 1'b0;
        end

        if (abort) begin
            state_d   = IDLE;
            we_c      = 1'b0;
            wr_ptr_d  = wr_ptr_q;
            cfg_err_d = cfg_err_q;
            s1_vld_d  = 1'b0;
            s1_last_d = 1'b0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign cfg_err = cfg_err_q;

endmodule
